// File: rtl/data_ram_resp_if.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_resp_if
// Brief    : Request/response bundle between the MEM stage and the data RAM.
// Revision : 1.0 - initial release
// ============================================================================
interface data_ram_resp_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_req;
    logic        ack;
    logic        err;

    // Requester side (pipeline MEM stage)
    modport master (
        output ce, we, addr, sel, data_i,
        input  data_o, stall_req, ack, err
    );

    // Responder side (the RAM)
    modport slave (
        input  ce, we, addr, sel, data_i,
        output data_o, stall_req, ack, err
    );
endinterface
`default_nettype wire

// File: rtl/data_ram_resp.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_resp
// Brief    : Word-addressed data RAM with programmable wait states, byte-lane
//            writes, out-of-range detection and a stall/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    data_ram_resp_if.slave  bus
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  sel_q;
    logic [31:0] wdata_q;
    logic [31:0] data_o_q;
    logic        ack_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic              out_of_range;
    logic              access_now;
    logic              mem_wr;

    // Decode the latched request; the access happens on the last BUSY cycle
    always_comb begin
        word_idx     = addr_q[ADDR_W+1:2];
        out_of_range = (addr_q >> (ADDR_W + 2)) != 32'd0;
        access_now   = (state_q == BUSY) && (cnt_q == 4'd0);
        mem_wr       = !rst && access_now && we_q && !out_of_range;
    end

    // Control FSM plus registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            data_o_q <= 32'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.ce) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.addr;
                        sel_q   <= bus.sel;
                        wdata_q <= bus.data_i;
                        cnt_q   <= WAIT_INIT;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                        err_q   <= out_of_range;
                        // Writes leave the read-data register untouched
                        if (!we_q) begin
                            data_o_q <= out_of_range ? 32'd0 : mem_q[word_idx];
                        end
                    end
                end
                DONE: begin
                    // ce is ignored here; requests are never queued
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Byte-lane write into the array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Stall is raised combinationally on the accepting cycle so the pipeline
    // holds immediately; reset forces it low
    assign bus.stall_req = !rst && (((state_q == IDLE) && bus.ce) || (state_q == BUSY));
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.data_o    = data_o_q;

endmodule
`default_nettype wire
